// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states,
// the per-completion flag record, and a helper that says whether a request
// needs the iterative multiply/divide datapath.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_CMP = 3'b101,
    OP_MUL = 3'b110,
    OP_DIV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic dz_err;
  } flags_t;

  // MUL always iterates; DIV iterates only for a non-zero divisor.
  function automatic logic needs_iter(input op_e op, input logic b_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU.
//   Request : in_valid, in_ready, op, use_cf, data_a, data_b
//   Response: out_valid, out_ready, result (2*WIDTH), zero, carry, dz_err
// master = requester/consumer side, slave = the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic               use_cf;
  logic [WIDTH-1:0]   data_a;
  logic [WIDTH-1:0]   data_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               zero;
  logic               carry;
  logic               dz_err;

  modport master (
    output in_valid, op, use_cf, data_a, data_b, out_ready,
    input  in_ready, out_valid, result, zero, carry, dz_err
  );

  modport slave (
    input  in_valid, op, use_cf, data_a, data_b, out_ready,
    output in_ready, out_valid, result, zero, carry, dz_err
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per
// cycle for WIDTH cycles.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands (a, b) and begin; is_div selects divide
//   done       : high in the cycle whose rising edge performs the last step
//   product    : value after that last step; MUL {hi,lo} product,
//                DIV {remainder, quotient}
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             busy;
  logic             div_mode;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  // hi/lo act as {accumulator, multiplier} for MUL and {remainder, quotient}
  // for DIV, so both share one shift register pair.
  always_comb begin
    hi_nxt    = hi;
    lo_nxt    = lo;
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    if (div_mode) begin
      div_shift = {hi, lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      if (div_shift >= {1'b0, opnd}) begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      hi_nxt  = mul_sum[WIDTH:1];
      lo_nxt  = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // done/product are taken from the final step's next values so the caller
  // can register the result on the same edge as the last iteration.
  assign done    = busy && (count == CW'(WIDTH - 1));
  assign product = {hi_nxt, lo_nxt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      count    <= '0;
      hi       <= '0;
      lo       <= a;
      opnd     <= b;
    end else if (busy) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready request and response handshakes.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_seq_if slave; single-cycle ops (AND/OR/ADD/SUB/CMP/NOP,
//                DIV by zero) complete in one cycle, MUL/DIV iterate WIDTH
//                cycles in alu_seq_muldiv. Result and flags are registered
//                and held until the next completion.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  state_e             state;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] result_q;
  logic               zero_q;
  logic               carry_q;
  logic               dz_q;

  op_e                op_in;
  logic               accept;
  logic               b_zero;
  logic               start_md;
  logic               md_done;
  logic [2*WIDTH-1:0] md_product;

  logic               cin;
  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [2*WIDTH-1:0] calc_result;
  flags_t             calc_flags;

  assign op_in    = op_e'(bus.op);
  assign accept   = bus.in_valid && in_ready_q;
  assign b_zero   = (bus.data_b == '0);
  assign start_md = accept && needs_iter(op_in, b_zero);

  alu_seq_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_md),
    .is_div (op_in == OP_DIV),
    .a      (bus.data_a),
    .b      (bus.data_b),
    .done   (md_done),
    .product(md_product)
  );

  // Single-cycle datapath. SUB is evaluated one bit wider so the top bit of
  // the difference is exactly the borrow out of A - B - cin.
  always_comb begin
    cin         = bus.use_cf & carry_q;
    add_full    = {1'b0, bus.data_a} + {1'b0, bus.data_b} + {{WIDTH{1'b0}}, cin};
    sub_full    = {1'b0, bus.data_a} - {1'b0, bus.data_b} - {{WIDTH{1'b0}}, cin};
    calc_result = '0;
    calc_flags  = '{carry: 1'b0, zero: 1'b0, dz_err: 1'b0};
    unique case (op_in)
      OP_AND: calc_result[WIDTH-1:0] = bus.data_a & bus.data_b;
      OP_OR:  calc_result[WIDTH-1:0] = bus.data_a | bus.data_b;
      OP_ADD: begin
        calc_result[WIDTH-1:0] = add_full[WIDTH-1:0];
        calc_flags.carry       = add_full[WIDTH];
      end
      OP_SUB: begin
        calc_result[WIDTH-1:0] = sub_full[WIDTH-1:0];
        calc_flags.carry       = sub_full[WIDTH];
      end
      OP_CMP: calc_result[0] = (bus.data_a > bus.data_b);
      OP_DIV: begin
        calc_result       = {bus.data_a, {WIDTH{1'b1}}};
        calc_flags.dz_err = 1'b1;
      end
      OP_NOP: begin
        calc_flags.carry  = carry_q;
        calc_flags.dz_err = dz_q;
      end
      default: ;
    endcase
    calc_flags.zero = (calc_result == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (start_md) begin
              state <= ST_CALC;
            end else begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= calc_result;
              zero_q      <= calc_flags.zero;
              carry_q     <= calc_flags.carry;
              dz_q        <= calc_flags.dz_err;
            end
          end
        end
        ST_CALC: begin
          if (md_done) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= md_product;
            zero_q      <= (md_product == '0);
            carry_q     <= 1'b0;
            dz_q        <= 1'b0;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.dz_err    = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16 with hand-computed expectations.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with in_ready high; leaves the bench at posedge+1
  // with out_valid high (or the cycle bound exhausted).
  task automatic run_op(input op_e op, input logic cf, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat, output logic ready_low);
    bus.op       = op;
    bus.use_cf   = cf;
    bus.data_a   = a;
    bus.data_b   = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.data_a   = 16'hDEAD;
    bus.data_b   = 16'hBEEF;
    bus.use_cf   = ~cf;
    bus.op       = OP_NOP;
    lat       = 1;
    ready_low = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.in_ready) ready_low = 1'b0;
  endtask

  task automatic release_op(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle_rdy"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_idle_ov"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic expect_op(input string tag, input op_e op, input logic cf,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_lat, input logic [31:0] exp_res,
                           input logic exp_c, input logic exp_z, input logic exp_dz);
    int   lat;
    logic ready_low;
    run_op(op, cf, a, b, lat, ready_low);
    check({tag, "_lat"},   64'(lat), 64'(exp_lat));
    check({tag, "_rdy0"},  64'(ready_low), 64'd1);
    check({tag, "_res"},   64'(bus.result), 64'(exp_res));
    check({tag, "_carry"}, 64'(bus.carry), 64'(exp_c));
    check({tag, "_zero"},  64'(bus.zero), 64'(exp_z));
    check({tag, "_dz"},    64'(bus.dz_err), 64'(exp_dz));
    release_op(tag);
  endtask

  initial begin
    int          lat;
    logic        ready_low;
    logic [31:0] held;
    logic        seen_ov;

    bus.in_valid  = 1'b0;
    bus.op        = OP_NOP;
    bus.use_cf    = 1'b0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",   64'(bus.in_ready), 64'd1);
    check("rst_ov",    64'(bus.out_valid), 64'd0);
    check("rst_res",   64'(bus.result), 64'd0);
    check("rst_zero",  64'(bus.zero), 64'd0);
    check("rst_carry", 64'(bus.carry), 64'd0);
    check("rst_dz",    64'(bus.dz_err), 64'd0);
    rst_n = 1'b1;

    // Accepted on the first rising edge after release.
    expect_op("add_ovf",  OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    expect_op("add_cin",  OP_ADD, 1'b1, 16'h0000, 16'h0000, 1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    expect_op("sub_brw",  OP_SUB, 1'b0, 16'h0003, 16'h0005, 1, 32'h0000_FFFE, 1'b1, 1'b0, 1'b0);
    expect_op("sub_bin",  OP_SUB, 1'b1, 16'h0005, 16'h0004, 1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    expect_op("and",      OP_AND, 1'b0, 16'hF0F0, 16'h3C3C, 1, 32'h0000_3030, 1'b0, 1'b0, 1'b0);
    expect_op("or",       OP_OR,  1'b0, 16'hF0F0, 16'h0F00, 1, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0);
    expect_op("cmp_gt",   OP_CMP, 1'b0, 16'h0005, 16'h0003, 1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    expect_op("cmp_lt",   OP_CMP, 1'b0, 16'h0003, 16'h0005, 1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    expect_op("cmp_eq",   OP_CMP, 1'b0, 16'h0007, 16'h0007, 1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    expect_op("add_c1",   OP_ADD, 1'b0, 16'hFFFF, 16'h0002, 1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    expect_op("nop",      OP_NOP, 1'b0, 16'h1234, 16'h5678, 1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    expect_op("add_keep", OP_ADD, 1'b1, 16'hFFFF, 16'h0000, 1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    expect_op("mul_max",  OP_MUL, 1'b0, 16'hFFFF, 16'hFFFF, 17, 32'hFFFE_0001, 1'b0, 1'b0, 1'b0);
    expect_op("mul_sh",   OP_MUL, 1'b0, 16'h1234, 16'h0010, 17, 32'h0001_2340, 1'b0, 1'b0, 1'b0);
    expect_op("div",      OP_DIV, 1'b0, 16'd1000, 16'd7,    17, 32'h0006_008E, 1'b0, 1'b0, 1'b0);
    expect_op("div_z",    OP_DIV, 1'b0, 16'h1234, 16'h0000, 1, 32'h1234_FFFF, 1'b0, 1'b0, 1'b1);
    expect_op("add_dzc",  OP_ADD, 1'b0, 16'h0001, 16'h0002, 1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    expect_op("div_0n",   OP_DIV, 1'b0, 16'h0000, 16'h0005, 17, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

    // Hold in DONE with out_ready low; a competing request must be ignored.
    run_op(OP_AND, 1'b0, 16'hFFFF, 16'h00FF, lat, ready_low);
    check("hold_lat", 64'(lat), 64'd1);
    held = bus.result;
    check("hold_res0", 64'(held), 64'h0000_00FF);
    bus.op       = OP_ADD;
    bus.data_a   = 16'h1111;
    bus.data_b   = 16'h2222;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_res%0d", i), 64'(bus.result), 64'(held));
      check($sformatf("hold_ov%0d", i),  64'(bus.out_valid), 64'd1);
      check($sformatf("hold_rdy%0d", i), 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    release_op("hold");
    check("hold_keep", 64'(bus.result), 64'h0000_00FF);

    // Reset in the middle of a multiply.
    expect_op("pre_rst", OP_ADD, 1'b0, 16'hFFFF, 16'h0002, 1, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    bus.op       = OP_MUL;
    bus.data_a   = 16'h00FF;
    bus.data_b   = 16'h0002;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rdy",   64'(bus.in_ready), 64'd1);
    check("arst_ov",    64'(bus.out_valid), 64'd0);
    check("arst_res",   64'(bus.result), 64'd0);
    check("arst_carry", 64'(bus.carry), 64'd0);
    check("arst_zero",  64'(bus.zero), 64'd0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_ov = 1'b1;
    end
    check("arst_no_ov", 64'(seen_ov), 64'd0);
    expect_op("post_rst", OP_ADD, 1'b0, 16'h0002, 16'h0003, 1, 32'h0000_0005, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits (legal 4..32).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present on op/use_cf/data_a/data_b.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  001 AND, 010 OR, 011 ADD, 100 SUB, 101 CMP, 110 MUL, 111 DIV; 000 reserved.
REQ-007 use_cf  input  1  ADD/SUB consume the stored carry flag as carry/borrow in.
REQ-008 data_a  input  WIDTH  operand A, unsigned.
REQ-009 data_b  input  WIDTH  operand B, unsigned.
REQ-010 out_valid  output  1  result/flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  2*WIDTH  low half primary result; high half MUL upper product or DIV remainder, else 0.
REQ-013 zero  output  1  result == 0 over all 2*WIDTH bits.
REQ-014 carry  output  1  stored carry/borrow flag.
REQ-015 dz_err  output  1  last DIV had data_b == 0.

Function
REQ-016 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Request accepted on in_valid && in_ready; operands, op, use_cf and cin = use_cf & carry captured at acceptance.
REQ-018 AND/OR/ADD/SUB/CMP: IDLE -> DONE, out_valid asserted the cycle after acceptance (latency 1).
REQ-019 ADD: {carry, result[W-1:0]} = A + B + cin, width W+1.
REQ-020 SUB: result[W-1:0] = A - B - cin mod 2^W; carry = 1 iff A < B + cin (borrow).
REQ-021 CMP: result = 1 if A > B else 0; AND/OR bitwise; all three clear carry.
REQ-022 MUL: shift-add, one bit per cycle, IDLE -> CALC for WIDTH cycles -> DONE; out_valid at cycle WIDTH+1 after acceptance; result = full 2*WIDTH product; carry cleared.
REQ-023 DIV, B != 0: restoring division, same timing as MUL; result low = A / B, high = A % B; carry cleared, dz_err cleared.
REQ-024 DIV, B == 0: skip CALC, DONE after latency 1; low = all ones, high = A, dz_err = 1.
REQ-025 dz_err cleared by any non-DIV completion; zero recomputed at every completion.
REQ-026 DONE holds result/flags stable while out_valid && !out_ready; on out_ready -> IDLE, new request accepted the following cycle at the earliest.
REQ-027 carry/zero/dz_err/result retain values in IDLE until the next completion, so back-to-back ADD/SUB with use_cf chain multi-word arithmetic.
REQ-028 op 000: treated as CMP-free no-op, latency 1, result 0, zero 1, flags otherwise unchanged.
REQ-029 in_valid while not in_ready SHALL be ignored with no state change; operand changes during CALC SHALL not affect the result.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, in_ready 1, out_valid 0, result 0, zero 0, carry 0, dz_err 0, iteration counter 0.
REQ-031 Reset mid-CALC or mid-DONE SHALL abandon the operation with no output produced after release.
REQ-032 First request accepted on the first rising edge with rst_n high.

Structure
REQ-033 Shared package alu_seq_pkg: op code constants, FSM state enum, completion-flag record.
REQ-034 Iterative multiply/divide datapath in one sub-module alu_seq_muldiv (start, done, count, operand/partial registers); single-cycle ops and FSM in alu_seq.

Verification (WIDTH=16)
REQ-035 ADD 0xFFFF + 0x0001, use_cf 0 -> result 0x0000, carry 1, zero 1, out_valid 1 cycle after accept; then ADD 0x0000 + 0x0000 use_cf 1 -> result 0x0001, carry 0.
REQ-036 SUB 0x0003 - 0x0005 -> result 0xFFFE, carry 1; then SUB 0x0005 - 0x0004 use_cf 1 -> 0x0000, zero 1, carry 0.
REQ-037 MUL 0xFFFF * 0xFFFF -> result 0xFFFE0001, out_valid exactly 17 cycles after accept, in_ready 0 throughout.
REQ-038 DIV 1000 / 7 -> low 142, high 6, latency 17; DIV 0x1234 / 0 -> low 0xFFFF, high 0x1234, dz_err 1, latency 1.
REQ-039 out_ready held 0 for 5 cycles in DONE -> result/flags stable, in_ready 0; asserted -> IDLE next cycle.
REQ-040 rst_n pulsed low at CALC cycle 8 of a MUL -> all outputs reset value asynchronously, no out_valid after release, next ADD correct.
